// File: rtl/gpio_bank_ctrl_pkg.sv
// gpio_pkg: register offsets and reset values for the GPIO bank controller.
package gpio_pkg;

  localparam logic [15:0] GPIO_DATA_OFS  = 16'h0000;
  localparam logic [15:0] GPIO_DIR_OFS   = 16'h0004;
  localparam logic [15:0] GPIO_IN_OFS    = 16'h0008;
  localparam logic [15:0] GPIO_SET_OFS   = 16'h000C;
  localparam logic [15:0] GPIO_CLR_OFS   = 16'h0010;
  localparam logic [15:0] GPIO_TGL_OFS   = 16'h0014;
  localparam logic [15:0] GPIO_RISE_OFS  = 16'h0018;
  localparam logic [15:0] GPIO_FALL_OFS  = 16'h001C;
  localparam logic [15:0] GPIO_STAT_OFS  = 16'h0020;
  localparam logic [15:0] GPIO_MASK_OFS  = 16'h0024;

  localparam logic [31:0] GPIO_DATA_RST  = 32'h0000_0000;
  localparam logic [31:0] GPIO_DIR_RST   = 32'h0000_0000;
  localparam logic [31:0] GPIO_RISE_RST  = 32'h0000_0000;
  localparam logic [31:0] GPIO_FALL_RST  = 32'h0000_0000;
  localparam logic [31:0] GPIO_STAT_RST  = 32'h0000_0000;
  localparam logic [31:0] GPIO_MASK_RST  = 32'h0000_0000;

endpackage

// File: rtl/gpio_bank_ctrl_if.sv
// CPU register bus as seen by the GPIO bank: single-cycle strobes, no wait states.
interface gpio_bank_ctrl_if;
  logic [15:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        write_enable;
  logic        read_enable;
  logic        ready;

  modport master (output addr, data_in, write_enable, read_enable,
                  input  data_out, ready);
  modport slave  (input  addr, data_in, write_enable, read_enable,
                  output data_out, ready);
endinterface

// File: rtl/gpio_bank_ctrl_in_cond.sv
// gpio_in_cond: input synchroniser for the whole bank, with optional per-pin
// debounce when GPIO_DEBOUNCE_EN is defined.
module gpio_in_cond #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] cond_in
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced;

  // Multi-flop synchroniser chain for the asynchronous pad inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [WIDTH-1:0] cond_q;

  // Per-pin stability counter; a bounce back to the accepted value restarts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (synced[i] != cond_q[i]) begin
          if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
            cond_q[i] <= synced[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i]  <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign cond_in = cond_q;
`else
  localparam int unused_deb_cycles = DEB_CYCLES;
  assign cond_in = synced;
`endif

endmodule

// File: rtl/gpio_bank_ctrl.sv
// gpio_bank_ctrl: memory-mapped GPIO bank with atomic set/clear/toggle,
// synchronised inputs, edge detection, sticky W1C status and a level irq.
// Optional debounce on the input path is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  gpio_bank_ctrl_if.slave   bus,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  logic [WIDTH-1:0] data_q, data_d, dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [WIDTH-1:0] stat_q, stat_d, mask_q, mask_d;
  logic [WIDTH-1:0] prev_q, cond_in, rise, fall, w1c, wdata;
  logic [WIDTH-1:0] gpio_out_q, gpio_oe_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q;
  logic             unused_wdata;

  gpio_in_cond #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_in_cond (
    .clk     (clk),
    .reset_n (reset_n),
    .gpio_in (gpio_in),
    .cond_in (cond_in)
  );

  assign wdata        = bus.data_in[WIDTH-1:0];
  assign unused_wdata = ^bus.data_in;
  assign rise         = cond_in & ~prev_q & rise_en_q;
  assign fall         = ~cond_in & prev_q & fall_en_q;

  // Write decode; a new edge event outranks a simultaneous W1C on the same bit
  always_comb begin
    data_d    = data_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    mask_d    = mask_q;
    w1c       = '0;
    if (bus.write_enable) begin
      case (bus.addr)
        GPIO_DATA_OFS: data_d    = wdata;
        GPIO_DIR_OFS:  dir_d     = wdata;
        GPIO_SET_OFS:  data_d    = data_q | wdata;
        GPIO_CLR_OFS:  data_d    = data_q & ~wdata;
        GPIO_TGL_OFS:  data_d    = data_q ^ wdata;
        GPIO_RISE_OFS: rise_en_d = wdata;
        GPIO_FALL_OFS: fall_en_d = wdata;
        GPIO_STAT_OFS: w1c       = wdata;
        GPIO_MASK_OFS: mask_d    = wdata;
        default: ;
      endcase
    end
    stat_d = (stat_q & ~w1c) | rise | fall;
  end

  // Read mux over pre-write register values; write-only and unmapped read 0
  always_comb begin
    rdata_d = '0;
    case (bus.addr)
      GPIO_DATA_OFS: rdata_d = 32'(data_q);
      GPIO_DIR_OFS:  rdata_d = 32'(dir_q);
      GPIO_IN_OFS:   rdata_d = 32'(cond_in);
      GPIO_RISE_OFS: rdata_d = 32'(rise_en_q);
      GPIO_FALL_OFS: rdata_d = 32'(fall_en_q);
      GPIO_STAT_OFS: rdata_d = 32'(stat_q);
      GPIO_MASK_OFS: rdata_d = 32'(mask_q);
      default:       rdata_d = '0;
    endcase
  end

  // Register file, edge history, read data hold, pad and irq output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= WIDTH'(GPIO_DATA_RST);
      dir_q      <= WIDTH'(GPIO_DIR_RST);
      rise_en_q  <= WIDTH'(GPIO_RISE_RST);
      fall_en_q  <= WIDTH'(GPIO_FALL_RST);
      stat_q     <= WIDTH'(GPIO_STAT_RST);
      mask_q     <= WIDTH'(GPIO_MASK_RST);
      prev_q     <= '0;
      rdata_q    <= '0;
      gpio_out_q <= '0;
      gpio_oe_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      dir_q      <= dir_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      stat_q     <= stat_d;
      mask_q     <= mask_d;
      prev_q     <= cond_in;
      if (bus.read_enable) rdata_q <= rdata_d;
      gpio_out_q <= data_q & dir_q;
      gpio_oe_q  <= dir_q;
      irq_q      <= |(stat_q & mask_q);
    end
  end

  assign bus.data_out = rdata_q;
  assign bus.ready    = 1'b1;
  assign gpio_out     = gpio_out_q;
  assign gpio_oe      = gpio_oe_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed bench for gpio_bank_ctrl (WIDTH=8, SYNC_STAGES=2).
module tb_gpio_bank_ctrl;
  import gpio_pkg::*;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DEB   = 16;
`else
  localparam int DEB   = 0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] gpio_in = '0;
  logic [WIDTH-1:0] gpio_out, gpio_oe;
  logic             irq;
  int               total = 0;
  int               fails = 0;

  gpio_bank_ctrl_if bus ();

  gpio_bank_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEB_CYCLES(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.data_in = d;
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.read_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.read_enable = 1'b0;
    d = bus.data_out;
  endtask

  task automatic rdchk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  initial begin
    logic [15:0] offs [11];
    offs = '{GPIO_DATA_OFS, GPIO_DIR_OFS, GPIO_IN_OFS, GPIO_SET_OFS, GPIO_CLR_OFS,
             GPIO_TGL_OFS, GPIO_RISE_OFS, GPIO_FALL_OFS, GPIO_STAT_OFS, GPIO_MASK_OFS, 16'h0028};
    bus.addr = '0;
    bus.data_in = '0;
    bus.write_enable = 1'b0;
    bus.read_enable = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(1);

    // reset state
    chk("rst_oe", 32'(gpio_oe), 32'h0);
    chk("rst_out", 32'(gpio_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_dout", bus.data_out, 32'h0);
    chk("ready", 32'(bus.ready), 32'h1);
    for (int i = 0; i < 11; i++) rdchk($sformatf("rst_rd_%h", offs[i]), offs[i], 32'h0);

    // output data path and atomic ops
    wr(GPIO_DIR_OFS, 32'hFF);
    wr(GPIO_DATA_OFS, 32'hA5);
    cyc(1);
    chk("oe_ff", 32'(gpio_oe), 32'hFF);
    chk("out_a5", 32'(gpio_out), 32'hA5);
    rdchk("data_a5", GPIO_DATA_OFS, 32'hA5);
    wr(GPIO_SET_OFS, 32'h0A);
    cyc(1);
    chk("out_set", 32'(gpio_out), 32'hAF);
    rdchk("data_set", GPIO_DATA_OFS, 32'hAF);
    wr(GPIO_CLR_OFS, 32'h81);
    cyc(1);
    chk("out_clr", 32'(gpio_out), 32'h2E);
    rdchk("data_clr", GPIO_DATA_OFS, 32'h2E);
    wr(GPIO_TGL_OFS, 32'h11);
    cyc(1);
    chk("out_tgl", 32'(gpio_out), 32'h3F);
    rdchk("data_tgl", GPIO_DATA_OFS, 32'h3F);

    // pad output gated by direction, two cycles after the strobe
    wr(GPIO_DIR_OFS, 32'h0F);
    chk("out_lat1", 32'(gpio_out), 32'h3F);
    cyc(1);
    chk("out_dir", 32'(gpio_out), 32'h0F);
    chk("oe_0f", 32'(gpio_oe), 32'h0F);

    // width truncation, write-only and unmapped behaviour
    wr(GPIO_DATA_OFS, 32'hFFFF_FFFF);
    rdchk("data_trunc", GPIO_DATA_OFS, 32'h0000_00FF);
    rdchk("set_ro0", GPIO_SET_OFS, 32'h0);
    wr(16'h0028, 32'h1234_5678);
    rdchk("unmapped", 16'h0028, 32'h0);
    rdchk("data_after_unmapped", GPIO_DATA_OFS, 32'hFF);

    // simultaneous read and write returns pre-write value
    bus.addr = GPIO_DATA_OFS;
    bus.data_in = 32'h12;
    bus.write_enable = 1'b1;
    bus.read_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    bus.read_enable = 1'b0;
    chk("rw_old", bus.data_out, 32'hFF);
    chk("rw_hold", bus.data_out, 32'hFF);
    rdchk("rw_new", GPIO_DATA_OFS, 32'h12);

    // rising edge on pin 0 -> irq after SYNC+2 cycles
    wr(GPIO_RISE_OFS, 32'h01);
    wr(GPIO_MASK_OFS, 32'h01);
    gpio_in[0] = 1'b1;
    for (int i = 1; i <= SYNC + 1 + DEB; i++) begin
      cyc(1);
      chk($sformatf("irq_pre_%0d", i), 32'(irq), 32'h0);
    end
    cyc(1);
    chk("irq_set", 32'(irq), 32'h1);
    rdchk("stat_rise", GPIO_STAT_OFS, 32'h01);
    rdchk("in_pin0", GPIO_IN_OFS, 32'h01);
    wr(GPIO_STAT_OFS, 32'h01);
    chk("irq_w1c_1", 32'(irq), 32'h1);
    cyc(1);
    chk("irq_w1c_2", 32'(irq), 32'h0);
    rdchk("stat_clr", GPIO_STAT_OFS, 32'h0);

    // enabling rise while pin already high makes no event
    gpio_in[1] = 1'b1;
    gpio_in[2] = 1'b1;
    cyc(SYNC + DEB + 3);
    wr(GPIO_RISE_OFS, 32'h03);
    cyc(4);
    rdchk("no_level_evt", GPIO_STAT_OFS, 32'h0);
    rdchk("in_pins", GPIO_IN_OFS, 32'h07);

    // falling edge on pin 2 coincident with W1C: set wins
    wr(GPIO_FALL_OFS, 32'h04);
    gpio_in[2] = 1'b0;
    cyc(SYNC + DEB);
    wr(GPIO_STAT_OFS, 32'h04);
    rdchk("fall_set_wins", GPIO_STAT_OFS, 32'h04);
    cyc(1);
    chk("irq_masked", 32'(irq), 32'h0);
    wr(GPIO_STAT_OFS, 32'h04);
    rdchk("fall_w1c", GPIO_STAT_OFS, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // short pulse is filtered, long hold is accepted
    wr(GPIO_RISE_OFS, 32'h08);
    gpio_in[3] = 1'b1;
    cyc(10);
    gpio_in[3] = 1'b0;
    cyc(SYNC + DEB + 4);
    rdchk("deb_pulse_in", GPIO_IN_OFS, 32'h03);
    rdchk("deb_pulse_stat", GPIO_STAT_OFS, 32'h0);
    gpio_in[3] = 1'b1;
    cyc(DEB + SYNC);
    rdchk("deb_hold_in", GPIO_IN_OFS, 32'h0B);
`endif

    // asynchronous reset mid-operation, no events on release
    wr(GPIO_MASK_OFS, 32'hFF);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_oe", 32'(gpio_oe), 32'h0);
    chk("arst_out", 32'(gpio_out), 32'h0);
    chk("arst_dout", bus.data_out, 32'h0);
    cyc(2);
    reset_n = 1'b1;
    cyc(SYNC + DEB + 4);
    rdchk("arst_stat", GPIO_STAT_OFS, 32'h0);
    rdchk("arst_mask", GPIO_MASK_OFS, 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
